// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART baud/tx/rx blocks.
// Holds the rate codes, the default 16x-oversample divisors for a 50 MHz
// clock, the baud controller FSM state encoding and a divisor range check.
package uart_pkg;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_2400  = 2'b00;
  localparam rate_t RATE_4800  = 2'b01;
  localparam rate_t RATE_9600  = 2'b10;
  localparam rate_t RATE_19200 = 2'b11;

  localparam int unsigned DEF_DIV0 = 1302;
  localparam int unsigned DEF_DIV1 = 651;
  localparam int unsigned DEF_DIV2 = 326;
  localparam int unsigned DEF_DIV3 = 163;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  // A divisor of 1 would make the divide counter sit permanently at its
  // terminal value, and the counter is only 16 bits wide.
  function automatic bit div_ok(input int unsigned d);
    return (d >= 2) && (d < 65536);
  endfunction

endpackage

// File: rtl/baud_ctrl_if.sv
// baud_ctrl_if -- rate-change handshake, busy inputs and tick/status outputs
// of the baud controller.
//   cfg_valid/cfg_rate/cfg_ready : rate-change request handshake
//   tx_busy/rx_busy              : transmitter/receiver mid-frame flags
//   tick16/tick1                 : oversample and bit-rate enable pulses
//   rate_cur/cfg_pending         : rate in use, change-in-progress flag
// slave is the controller side, master is the requester/UART side.
interface baud_ctrl_if;
  import uart_pkg::*;

  logic  cfg_valid;
  rate_t cfg_rate;
  logic  cfg_ready;
  logic  tx_busy;
  logic  rx_busy;
  logic  tick16;
  logic  tick1;
  rate_t rate_cur;
  logic  cfg_pending;

  modport slave (
    input  cfg_valid, cfg_rate, tx_busy, rx_busy,
    output cfg_ready, tick16, tick1, rate_cur, cfg_pending
  );

  modport master (
    output cfg_valid, cfg_rate, tx_busy, rx_busy,
    input  cfg_ready, tick16, tick1, rate_cur, cfg_pending
  );

endinterface

// File: rtl/baud_tick_div.sv
// baud_tick_div -- divide counter plus 4-bit sub-counter.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : hold both counters at 0 and suppress ticks
//   div            : divide ratio (>= 2)
//   tick16         : one-cycle pulse every div clocks
//   tick1          : one-cycle pulse on every 16th tick16
module baud_tick_div (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [15:0] div,
  output logic        tick16,
  output logic        tick1
);

  logic [15:0] div_cnt;
  logic [3:0]  sub_cnt;
  logic        at_top;

  assign at_top = (div_cnt == (div - 16'd1));
  // Ticks are gated by clear so a stale count never fires during a reload.
  assign tick16 = !clear && at_top;
  assign tick1  = tick16 && (sub_cnt == 4'd15);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 16'd0;
      sub_cnt <= 4'd0;
    end else if (clear) begin
      div_cnt <= 16'd0;
      sub_cnt <= 4'd0;
    end else begin
      div_cnt <= at_top ? 16'd0 : div_cnt + 16'd1;
      if (tick16) sub_cnt <= sub_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// baud_ctrl -- baud tick generator with glitch-free rate changes.
//   clock, reset_n : system clock, asynchronous active-low reset
//   enable         : run request; low stops ticks
//   bus            : baud_ctrl_if.slave (rate handshake, busy flags, ticks,
//                    current rate, pending flag)
// A rate change accepted while running waits in DRAIN until neither the
// transmitter nor the receiver is mid-frame, then LOAD swaps the rate and
// restarts the divider, so no frame ever sees two bit rates.
module baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV0       = DEF_DIV0,
  parameter int unsigned DIV1       = DEF_DIV1,
  parameter int unsigned DIV2       = DEF_DIV2,
  parameter int unsigned DIV3       = DEF_DIV3,
  parameter rate_t       RESET_RATE = RATE_9600
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  baud_ctrl_if.slave  bus
);

  if (!div_ok(DIV0) || !div_ok(DIV1) || !div_ok(DIV2) || !div_ok(DIV3)) begin : g_bad_div
    $error("baud_ctrl: every divisor must be >= 2 and < 65536");
  end

  logic [1:0]  state;
  rate_t       rate_cur;
  rate_t       pending;
  logic        accept;
  logic        clear;
  logic [15:0] div_sel;

  assign bus.cfg_ready   = (state == ST_OFF) || (state == ST_RUN);
  assign bus.cfg_pending = (state == ST_DRAIN) || (state == ST_LOAD);
  assign bus.rate_cur    = rate_cur;
  assign accept          = bus.cfg_valid && bus.cfg_ready;
  assign clear           = (state == ST_OFF) || (state == ST_LOAD);

  always_comb begin
    div_sel = 16'(DIV2);
    case (rate_cur)
      RATE_2400:  div_sel = 16'(DIV0);
      RATE_4800:  div_sel = 16'(DIV1);
      RATE_9600:  div_sel = 16'(DIV2);
      RATE_19200: div_sel = 16'(DIV3);
      default:    div_sel = 16'(DIV2);
    endcase
  end

  baud_tick_div u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .div     (div_sel),
    .tick16  (bus.tick16),
    .tick1   (bus.tick1)
  );

  // While stopped (or being stopped) there is no frame to protect, so an
  // accepted rate takes effect at once; dropping enable in DRAIN applies the
  // waiting rate on the way to OFF.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_OFF;
      rate_cur <= RESET_RATE;
      pending  <= RESET_RATE;
    end else begin
      if (accept) pending <= bus.cfg_rate;
      case (state)
        ST_OFF: begin
          if (accept) rate_cur <= bus.cfg_rate;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_OFF;
            if (accept) rate_cur <= bus.cfg_rate;
          end else if (accept) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!enable) begin
            state    <= ST_OFF;
            rate_cur <= pending;
          end else if (!bus.tx_busy && !bus.rx_busy) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rate_cur <= pending;
          state    <= enable ? ST_RUN : ST_OFF;
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_ctrl.sv
// tb_baud_ctrl -- directed self-checking bench for baud_ctrl with default
// divisors (2400/4800/9600/19200 baud at 50 MHz).
module tb_baud_ctrl;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic enable;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cyc        = 0;

  baud_ctrl_if bif();

  baud_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bif)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [1:0] rate,
                               input logic txb, input logic rxb);
    enable        = en;
    bif.cfg_valid = valid;
    bif.cfg_rate  = rate;
    bif.tx_busy   = txb;
    bif.rx_busy   = rxb;
  endtask

  // Steps until the chosen tick is seen; at = cycle of the tick or -1.
  task automatic waitTick(input string tag, input bit wantTick1, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((wantTick1 ? bif.tick1 : bif.tick16) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  int s0, sL, t1, t2, a1, a2, prev, nTicks, badGaps;

  initial begin
    // Reset values, checked while reset is still asserted.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    stepN(3);
    checkOutput("rst_rate_cur", bif.rate_cur, 2);
    checkOutput("rst_cfg_ready", bif.cfg_ready, 1);
    checkOutput("rst_cfg_pending", bif.cfg_pending, 0);
    checkOutput("rst_tick16", bif.tick16, 0);
    checkOutput("rst_tick1", bif.tick1, 0);
    reset_n = 1'b1;
    step();

    // 9600 baud: tick16 every 326, tick1 every 5216.
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    s0 = cyc;
    waitTick("first_tick16", 1'b0, 400, t1);
    checkOutput("first_tick16_latency", t1 - s0, 325);
    step();
    checkOutput("tick16_width", bif.tick16, 0);
    waitTick("tick16_b", 1'b0, 400, t2);
    checkOutput("tick16_period_9600", t2 - t1, 326);
    waitTick("tick1_a", 1'b1, 6000, a1);
    checkOutput("first_tick1_latency", a1 - s0, 5215);
    checkOutput("tick1_with_tick16", bif.tick16, 1);
    waitTick("tick1_b", 1'b1, 6000, a2);
    checkOutput("tick1_period_9600", a2 - a1, 5216);
    checkOutput("rate_cur_9600", bif.rate_cur, 2);

    // Change to 19200 while the transmitter is busy.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    checkOutput("drain_cfg_ready", bif.cfg_ready, 0);
    checkOutput("drain_cfg_pending", bif.cfg_pending, 1);
    prev = -1; nTicks = 0; badGaps = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bif.tick16 === 1'b1) begin
        if (prev >= 0 && (cyc - prev) != 326) badGaps++;
        prev = cyc;
        nTicks++;
      end
    end
    checkOutput("drain_tick_gaps", badGaps, 0);
    checkOutput("drain_tick_count", nTicks, 3);
    checkOutput("drain_still_pending", bif.cfg_pending, 1);
    checkOutput("drain_old_rate", bif.rate_cur, 2);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    step();
    sL = cyc;
    checkOutput("load_tick16", bif.tick16, 0);
    checkOutput("load_cfg_pending", bif.cfg_pending, 1);
    checkOutput("load_cfg_ready", bif.cfg_ready, 0);
    step();
    checkOutput("run_rate_19200", bif.rate_cur, 3);
    checkOutput("run_cfg_pending", bif.cfg_pending, 0);
    waitTick("tick16_19200_a", 1'b0, 300, t1);
    checkOutput("load_to_tick16", t1 - sL, 163);
    waitTick("tick16_19200_b", 1'b0, 300, t2);
    checkOutput("tick16_period_19200", t2 - t1, 163);

    // enable dropped mid-DRAIN with 4800 pending.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    stepN(5);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    step();
    checkOutput("off_tick16", bif.tick16, 0);
    checkOutput("off_rate_4800", bif.rate_cur, 1);
    checkOutput("off_cfg_pending", bif.cfg_pending, 0);
    checkOutput("off_cfg_ready", bif.cfg_ready, 1);
    nTicks = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bif.tick16 === 1'b1 || bif.tick1 === 1'b1) nTicks++;
    end
    checkOutput("off_no_ticks", nTicks, 0);

    // Rate change while OFF is immediate; then 2400 baud.
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    step();
    checkOutput("off_rate_2400", bif.rate_cur, 0);
    checkOutput("off_accept_no_tick", bif.tick16, 0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    s0 = cyc;
    waitTick("tick16_2400", 1'b0, 1500, t1);
    checkOutput("first_tick16_2400", t1 - s0, 1301);

    // Request held during DRAIN is ignored, then taken on first RUN cycle.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    stepN(20);
    checkOutput("rx_busy_holds_ready", bif.cfg_ready, 0);
    checkOutput("rx_busy_holds_pending", bif.cfg_pending, 1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    step();
    checkOutput("load2_rate_unchanged", bif.rate_cur, 0);
    step();
    checkOutput("held_req_ignored", bif.rate_cur, 3);
    checkOutput("first_run_ready", bif.cfg_ready, 1);
    step();
    checkOutput("held_req_accepted", bif.cfg_pending, 1);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    stepN(2);
    checkOutput("held_req_applied", bif.rate_cur, 1);

    // Reset mid-DRAIN discards the 19200 request.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    step();
    checkOutput("pre_reset_pending", bif.cfg_pending, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_pending", bif.cfg_pending, 0);
    checkOutput("async_rst_rate", bif.rate_cur, 2);
    checkOutput("async_rst_ready", bif.cfg_ready, 1);
    checkOutput("async_rst_tick16", bif.tick16, 0);
    step();
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    s0 = cyc;
    checkOutput("post_rst_rate", bif.rate_cur, 2);
    waitTick("post_rst_tick16", 1'b0, 400, t1);
    checkOutput("post_rst_latency", t1 - s0, 325);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
